// File: rtl/ysyx_22040895_pc_gen.sv
// Fetch-PC generator: BOOT/RUN/HALT FSM driving the next fetch address with trap > branch > sequential priority.
// Latency: one cycle from any request (redirect, fire, halt, wakeup) to the updated pc_o / status outputs.
// Backpressure: while fetch_ready_i is low, pc_o and pc_valid_o hold; only a redirect or halt changes them.
module ysyx_22040895_pc_gen #(
  parameter int          XLEN        = 64,
  parameter logic [63:0] RESET_VEC   = 64'h0000_0000_8000_0000,
  parameter int          INST_BYTES  = 4,
  parameter bit          ALIGN_CHECK = 1'b1,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_ready_i,
  input  logic             br_valid_i,
  input  logic [XLEN-1:0]  br_target_i,
  input  logic             trap_valid_i,
  input  logic [XLEN-1:0]  trap_vec_i,
  input  logic             halt_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             pc_valid_o,
  output logic             misalign_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] redir_cnt_o
);

  localparam logic [XLEN-1:0]  RST_PC   = RESET_VEC[XLEN-1:0];
  localparam logic [XLEN-1:0]  STEP     = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0]  LOW_MASK = XLEN'(INST_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   pc_d;
  logic              mis_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              load;
  logic              step;
  logic              fire;
  logic [XLEN-1:0]   tgt_raw;
  logic [XLEN-1:0]   tgt_ld;
  logic [XLEN-1:0]   low_bits;
  logic              tgt_mis;

  assign fire = pc_valid_o & fetch_ready_i;

  // Next-state and redirect selection; trap always outranks branch, and HALT only listens to trap.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    tgt_raw = trap_vec_i;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        if (trap_valid_i) begin
          load = 1'b1;
        end else if (br_valid_i) begin
          load    = 1'b1;
          tgt_raw = br_target_i;
        end
      end
      RUN: begin
        if (trap_valid_i) begin
          // a trap overrides a simultaneous halt: keep running at the vector
          load = 1'b1;
        end else begin
          if (br_valid_i) begin
            load    = 1'b1;
            tgt_raw = br_target_i;
          end else if (fire) begin
            step = 1'b1;
          end
          if (halt_i) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        if (trap_valid_i) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Target alignment: clear sub-instruction bits and flag when any were set.
  assign low_bits = tgt_raw & LOW_MASK;
  assign tgt_ld   = ALIGN_CHECK ? (tgt_raw & ~LOW_MASK) : tgt_raw;
  assign tgt_mis  = ALIGN_CHECK && load && (low_bits != '0);

  // Next PC: redirect, else sequential step on an accepted fetch, else hold.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = tgt_ld;
    end else if (step) begin
      pc_d = pc_q + STEP;
    end
  end

  // State, PC, misalign pulse and saturating redirect counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RST_PC;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= tgt_mis;
      if (load && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = (state_q == RUN);
  assign halted_o    = (state_q == HALT);
  assign misalign_o  = mis_q;
  assign redir_cnt_o = cnt_q;

endmodule
